// File: rtl/reservation_station.sv
// Reservation station: an eight-slot ALU issue buffer. It captures operations from the
// register file and decoder, and it wakes operands by snooping the ALU and load/store
// result buses. Each cycle it issues the lowest-index ready operation to the ALU.
module reservation_station #(
  parameter int Entries    = 8,
  parameter int IndexWidth = 3,
  parameter int DataLength = 31,
  parameter int PcLength   = 31,
  parameter int OpLength   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                is_exception_from_rob,
  input  logic                is_valid_from_decoder,
  input  logic [OpLength:0]   op_from_decoder,
  input  logic [DataLength:0] imm_from_decoder,
  input  logic [PcLength:0]   pc_from_rf,
  input  logic [DataLength:0] v1_from_rf,
  input  logic [DataLength:0] v2_from_rf,
  input  logic [PcLength:0]   q1_from_rf,
  input  logic [PcLength:0]   q2_from_rf,
  input  logic                cdb_alu_valid,
  input  logic [PcLength:0]   cdb_alu_tag,
  input  logic [DataLength:0] cdb_alu_data,
  input  logic                cdb_lsb_valid,
  input  logic [PcLength:0]   cdb_lsb_tag,
  input  logic [DataLength:0] cdb_lsb_data,
  output logic                is_full_to_decoder,
  output logic                valid_to_alu,
  output logic [OpLength:0]   op_to_alu,
  output logic [DataLength:0] v1_to_alu,
  output logic [DataLength:0] v2_to_alu,
  output logic [DataLength:0] imm_to_alu,
  output logic [PcLength:0]   pc_to_alu
);

  logic [Entries-1:0]  busy;
  logic [OpLength:0]   entry_op  [Entries];
  logic [DataLength:0] entry_imm [Entries];
  logic [PcLength:0]   entry_pc  [Entries];
  logic [DataLength:0] entry_v1  [Entries];
  logic [DataLength:0] entry_v2  [Entries];
  logic [PcLength:0]   entry_q1  [Entries];
  logic [PcLength:0]   entry_q2  [Entries];
  logic [IndexWidth:0] count;

  logic                  free_found;
  logic [IndexWidth-1:0] free_idx;
  logic                  ready_found;
  logic [IndexWidth-1:0] ready_idx;
  logic                  alloc;

  // A pending tag matches a bus only when the bus is valid and the tag is non-zero.
  // The ALU bus is tested first everywhere, so it wins when both buses carry the same tag.
  function automatic logic alu_hit(input logic [PcLength:0] q);
    return (q != '0) && cdb_alu_valid && (cdb_alu_tag == q);
  endfunction

  function automatic logic lsb_hit(input logic [PcLength:0] q);
    return (q != '0) && cdb_lsb_valid && (cdb_lsb_tag == q);
  endfunction

  assign is_full_to_decoder = (count == (IndexWidth+1)'(Entries));
  assign alloc = is_valid_from_decoder && !is_full_to_decoder && free_found;

  // Lowest-index free slot and lowest-index ready slot, both taken from registered state.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise paths that do not
    // assign it infer a latch; blocking '=' belongs here, and '<=' belongs in always_ff.
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int i = Entries - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IndexWidth'(i);
      end
      if (busy[i] && entry_q1[i] == '0 && entry_q2[i] == '0) begin
        ready_found = 1'b1;
        ready_idx   = IndexWidth'(i);
      end
    end
  end

  // Flush or reset, otherwise do wakeup, issue and allocation together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the busy bits and the outputs need a reset. The payload arrays are
      // ignored while an entry is not busy, so they carry no reset.
      busy         <= '0;
      count        <= '0;
      valid_to_alu <= 1'b0;
      op_to_alu    <= '0;
      v1_to_alu    <= '0;
      v2_to_alu    <= '0;
      imm_to_alu   <= '0;
      pc_to_alu    <= '0;
    end else if (is_exception_from_rob) begin
      busy         <= '0;
      count        <= '0;
      valid_to_alu <= 1'b0;
    end else begin
      for (int i = 0; i < Entries; i++) begin
        if (busy[i]) begin
          if (alu_hit(entry_q1[i])) begin
            entry_v1[i] <= cdb_alu_data;
            entry_q1[i] <= '0;
          end else if (lsb_hit(entry_q1[i])) begin
            entry_v1[i] <= cdb_lsb_data;
            entry_q1[i] <= '0;
          end
          if (alu_hit(entry_q2[i])) begin
            entry_v2[i] <= cdb_alu_data;
            entry_q2[i] <= '0;
          end else if (lsb_hit(entry_q2[i])) begin
            entry_v2[i] <= cdb_lsb_data;
            entry_q2[i] <= '0;
          end
        end
      end

      valid_to_alu <= ready_found;
      if (ready_found) begin
        busy[ready_idx] <= 1'b0;
        op_to_alu       <= entry_op[ready_idx];
        v1_to_alu       <= entry_v1[ready_idx];
        v2_to_alu       <= entry_v2[ready_idx];
        imm_to_alu      <= entry_imm[ready_idx];
        pc_to_alu       <= entry_pc[ready_idx];
      end

      // The free slot is never the issuing slot, so both writes can land on the same edge.
      if (alloc) begin
        busy[free_idx]      <= 1'b1;
        entry_op[free_idx]  <= op_from_decoder;
        entry_imm[free_idx] <= imm_from_decoder;
        entry_pc[free_idx]  <= pc_from_rf;
        if (alu_hit(q1_from_rf)) begin
          entry_v1[free_idx] <= cdb_alu_data;
          entry_q1[free_idx] <= '0;
        end else if (lsb_hit(q1_from_rf)) begin
          entry_v1[free_idx] <= cdb_lsb_data;
          entry_q1[free_idx] <= '0;
        end else begin
          entry_v1[free_idx] <= v1_from_rf;
          entry_q1[free_idx] <= q1_from_rf;
        end
        if (alu_hit(q2_from_rf)) begin
          entry_v2[free_idx] <= cdb_alu_data;
          entry_q2[free_idx] <= '0;
        end else if (lsb_hit(q2_from_rf)) begin
          entry_v2[free_idx] <= cdb_lsb_data;
          entry_q2[free_idx] <= '0;
        end else begin
          entry_v2[free_idx] <= v2_from_rf;
          entry_q2[free_idx] <= q2_from_rf;
        end
      end

      count <= count + (IndexWidth+1)'(alloc) - (IndexWidth+1)'(ready_found);
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station. Expected issues are queued as stimulus is
// driven, then popped and compared whenever valid_to_alu is seen.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_exception_from_rob;
  logic        is_valid_from_decoder;
  logic [5:0]  op_from_decoder;
  logic [31:0] imm_from_decoder;
  logic [31:0] pc_from_rf;
  logic [31:0] v1_from_rf, v2_from_rf;
  logic [31:0] q1_from_rf, q2_from_rf;
  logic        cdb_alu_valid;
  logic [31:0] cdb_alu_tag, cdb_alu_data;
  logic        cdb_lsb_valid;
  logic [31:0] cdb_lsb_tag, cdb_lsb_data;
  logic        is_full_to_decoder;
  logic        valid_to_alu;
  logic [5:0]  op_to_alu;
  logic [31:0] v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
  } issue_t;

  issue_t sb[$];
  int     errors = 0;
  int     checks = 0;

  reservation_station dut (
    .clk                   (clk),
    .rst                   (rst),
    .is_exception_from_rob (is_exception_from_rob),
    .is_valid_from_decoder (is_valid_from_decoder),
    .op_from_decoder       (op_from_decoder),
    .imm_from_decoder      (imm_from_decoder),
    .pc_from_rf            (pc_from_rf),
    .v1_from_rf            (v1_from_rf),
    .v2_from_rf            (v2_from_rf),
    .q1_from_rf            (q1_from_rf),
    .q2_from_rf            (q2_from_rf),
    .cdb_alu_valid         (cdb_alu_valid),
    .cdb_alu_tag           (cdb_alu_tag),
    .cdb_alu_data          (cdb_alu_data),
    .cdb_lsb_valid         (cdb_lsb_valid),
    .cdb_lsb_tag           (cdb_lsb_tag),
    .cdb_lsb_data          (cdb_lsb_data),
    .is_full_to_decoder    (is_full_to_decoder),
    .valid_to_alu          (valid_to_alu),
    .op_to_alu             (op_to_alu),
    .v1_to_alu             (v1_to_alu),
    .v2_to_alu             (v2_to_alu),
    .imm_to_alu            (imm_to_alu),
    .pc_to_alu             (pc_to_alu)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge, then sample. Any issue must match the head of the scoreboard.
  task automatic step();
    issue_t exp_item;
    @(posedge clk);
    #1;
    if (valid_to_alu === 1'b1) begin
      check("issue_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_item = sb.pop_front();
        check("issue_op",  32'(op_to_alu), 32'(exp_item.op));
        check("issue_v1",  v1_to_alu,      exp_item.v1);
        check("issue_v2",  v2_to_alu,      exp_item.v2);
        check("issue_imm", imm_to_alu,     exp_item.imm);
        check("issue_pc",  pc_to_alu,      exp_item.pc);
      end
    end
  endtask

  task automatic drive_alloc(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] pc,
                             input logic [31:0] v1, input logic [31:0] v2,
                             input logic [31:0] q1, input logic [31:0] q2);
    is_valid_from_decoder = 1'b1;
    op_from_decoder       = op;
    imm_from_decoder      = imm;
    pc_from_rf            = pc;
    v1_from_rf            = v1;
    v2_from_rf            = v2;
    q1_from_rf            = q1;
    q2_from_rf            = q2;
  endtask

  task automatic idle_inputs();
    is_valid_from_decoder = 1'b0;
    is_exception_from_rob = 1'b0;
    cdb_alu_valid         = 1'b0;
    cdb_alu_tag           = '0;
    cdb_alu_data          = '0;
    cdb_lsb_valid         = 1'b0;
    cdb_lsb_tag           = '0;
    cdb_lsb_data          = '0;
  endtask

  task automatic expect_idle(input string tag);
    check(tag, 32'(valid_to_alu), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    drive_alloc(6'd0, '0, '0, '0, '0, '0, '0);
    is_valid_from_decoder = 1'b0;

    // Reset held for two edges.
    step();
    step();
    expect_idle("reset_valid");
    check("reset_full", 32'(is_full_to_decoder), 32'd0);
    check("reset_op",   32'(op_to_alu), 32'd0);
    check("reset_v1",   v1_to_alu, 32'd0);
    check("reset_v2",   v2_to_alu, 32'd0);
    check("reset_imm",  imm_to_alu, 32'd0);
    check("reset_pc",   pc_to_alu, 32'd0);
    rst = 1'b0;

    // A ready op issues one edge after allocation, for exactly one cycle.
    drive_alloc(6'd3, 32'h11, 32'h1000, 32'd5, 32'd7, '0, '0);
    sb.push_back('{op: 6'd3, v1: 32'd5, v2: 32'd7, imm: 32'h11, pc: 32'h1000});
    step();
    is_valid_from_decoder = 1'b0;
    expect_idle("no_issue_same_cycle");
    step();
    check("ready_issued", 32'(valid_to_alu), 32'd1);
    step();
    expect_idle("single_cycle_valid");

    // The op waits on q1 until the ALU bus broadcasts its tag.
    drive_alloc(6'd1, 32'h0, 32'h1100, 32'd0, 32'd4, 32'h100, '0);
    step();
    is_valid_from_decoder = 1'b0;
    expect_idle("wait_q1_a");
    step();
    expect_idle("wait_q1_b");
    cdb_alu_valid = 1'b1; cdb_alu_tag = 32'h100; cdb_alu_data = 32'h2a;
    sb.push_back('{op: 6'd1, v1: 32'h2a, v2: 32'd4, imm: 32'h0, pc: 32'h1100});
    step();
    idle_inputs();
    expect_idle("wake_edge_no_issue");
    step();
    check("woken_issued", 32'(valid_to_alu), 32'd1);

    // The operand is forwarded from the load/store bus in the same cycle it is allocated.
    drive_alloc(6'd2, 32'h22, 32'h1200, 32'd3, 32'd0, '0, 32'h200);
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 32'h200; cdb_lsb_data = 32'd9;
    sb.push_back('{op: 6'd2, v1: 32'd3, v2: 32'd9, imm: 32'h22, pc: 32'h1200});
    step();
    idle_inputs();
    expect_idle("fwd_alloc_edge");
    step();
    check("fwd_issued", 32'(valid_to_alu), 32'd1);

    // When both buses carry the same tag, the ALU bus value is taken.
    drive_alloc(6'd5, 32'h0, 32'h1300, 32'd0, 32'd1, 32'h250, '0);
    step();
    is_valid_from_decoder = 1'b0;
    cdb_alu_valid = 1'b1; cdb_alu_tag = 32'h250; cdb_alu_data = 32'haa;
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 32'h250; cdb_lsb_data = 32'hbb;
    sb.push_back('{op: 6'd5, v1: 32'haa, v2: 32'd1, imm: 32'h0, pc: 32'h1300});
    step();
    idle_inputs();
    step();
    check("alu_priority_issued", 32'(valid_to_alu), 32'd1);

    // Fill all eight slots, then check that a ninth request is dropped.
    for (int i = 0; i < 8; i++) begin
      drive_alloc(6'd4, 32'h0, 32'h3000 + 32'(i), 32'd0, 32'(i), 32'h300 + 32'(i), '0);
      step();
    end
    is_valid_from_decoder = 1'b0;
    check("full_after_8", 32'(is_full_to_decoder), 32'd1);
    drive_alloc(6'd7, 32'h0, 32'h2000, 32'd1, 32'd1, '0, '0);
    step();
    is_valid_from_decoder = 1'b0;
    expect_idle("dropped_no_issue");
    check("full_hold", 32'(is_full_to_decoder), 32'd1);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 32'h303; cdb_alu_data = 32'h77;
    sb.push_back('{op: 6'd4, v1: 32'h77, v2: 32'd3, imm: 32'h0, pc: 32'h3003});
    step();
    idle_inputs();
    check("full_before_issue", 32'(is_full_to_decoder), 32'd1);
    step();
    check("entry3_issued", 32'(valid_to_alu), 32'd1);
    check("full_cleared", 32'(is_full_to_decoder), 32'd0);
    step();
    expect_idle("no_dropped_op");
    is_exception_from_rob = 1'b1;
    step();
    idle_inputs();
    check("flush1_full", 32'(is_full_to_decoder), 32'd0);

    // Slots 1 and 5 wake on the same edge. The lower index issues first.
    for (int i = 0; i < 6; i++) begin
      drive_alloc(6'd8 + 6'(i), 32'h0, 32'h4000 + 32'(i), 32'd0, 32'(i), 32'h400 + 32'(i), '0);
      step();
    end
    is_valid_from_decoder = 1'b0;
    cdb_alu_valid = 1'b1; cdb_alu_tag = 32'h401; cdb_alu_data = 32'h51;
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 32'h405; cdb_lsb_data = 32'h55;
    sb.push_back('{op: 6'd9,  v1: 32'h51, v2: 32'd1, imm: 32'h0, pc: 32'h4001});
    sb.push_back('{op: 6'd13, v1: 32'h55, v2: 32'd5, imm: 32'h0, pc: 32'h4005});
    step();
    idle_inputs();
    step();
    check("idx1_first_pc", pc_to_alu, 32'h4001);
    step();
    check("idx5_second_pc", pc_to_alu, 32'h4005);

    // Flush with four slots busy. The allocation and wakeup presented in the same cycle are discarded.
    is_exception_from_rob = 1'b1;
    drive_alloc(6'd2, 32'h0, 32'h5000, 32'd1, 32'd1, '0, '0);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 32'h400; cdb_alu_data = 32'h1;
    step();
    idle_inputs();
    expect_idle("flush_valid");
    check("flush_full", 32'(is_full_to_decoder), 32'd0);
    step();
    expect_idle("flush_alloc_discarded");
    cdb_alu_valid = 1'b1; cdb_alu_tag = 32'h402; cdb_alu_data = 32'h2;
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 32'h403; cdb_lsb_data = 32'h3;
    step();
    cdb_alu_tag = 32'h400; cdb_lsb_tag = 32'h404;
    step();
    idle_inputs();
    step();
    expect_idle("old_tags_no_issue_a");
    step();
    expect_idle("old_tags_no_issue_b");

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
